// File: rtl/regbank_stream_reader.sv
// rtl/regbank_stream_reader.sv - register bank with a valid/ready burst read engine
module regbank_stream_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_start,
    input  logic [AW-1:0]    rd_addr,
    input  logic [AW:0]      rd_len,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_last,
    output logic             rd_busy
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_W   = (AW+1)'(1);

    state_t           state, state_n;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr, ptr_n;
    logic [AW:0]      rem, rem_n;
    logic [AW:0]      len_eff;
    logic [WIDTH-1:0] data_n;
    logic             valid_n, last_n;

    assign len_eff = (rd_len > DEPTH_W) ? DEPTH_W : rd_len;
    assign rd_busy = (state == STREAM);

    // Reads sample mem before this edge's write lands, giving read-before-write.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        rem_n   = rem;
        data_n  = rd_data;
        valid_n = rd_valid;
        last_n  = rd_last;
        case (state)
            IDLE: begin
                if (rd_start && len_eff != '0) begin
                    state_n = STREAM;
                    data_n  = mem[rd_addr];
                    ptr_n   = rd_addr + 1'b1;
                    rem_n   = len_eff - 1'b1;
                    valid_n = 1'b1;
                    last_n  = (len_eff == ONE_W);
                end
            end
            STREAM: begin
                if (rd_valid && rd_ready) begin
                    if (rd_last) begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                    end else begin
                        data_n = mem[ptr];
                        ptr_n  = ptr + 1'b1;
                        rem_n  = rem - 1'b1;
                        last_n = (rem == ONE_W);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            rem      <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            rem      <= rem_n;
            rd_valid <= valid_n;
            rd_data  <= data_n;
            rd_last  <= last_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_regbank_stream_reader.sv
// tb/tb_regbank_stream_reader.sv - directed and random bursts against a memory-array model
module tb_regbank_stream_reader;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_start;
    logic [2:0] rd_addr;
    logic [3:0] rd_len;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       rd_busy;

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    logic [7:0] ref_mem [DEPTH];

    regbank_stream_reader dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_start (rd_start),
        .rd_addr  (rd_addr),
        .rd_len   (rd_len),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .rd_busy  (rd_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_write(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = 3'(a);
        wr_data = 8'(d);
        @(negedge clk);
        wr_en = 1'b0;
        ref_mem[a] = 8'(d);
    endtask

    // The word at addr is captured before a same-edge write; later words see the new value.
    task automatic burst(input int addr, input int len, input bit rnd_ready, input bit inject,
                         input bit cw, input int cw_data);
        logic [7:0] exp_q [$];
        int eff;
        int i;
        int cyc;
        eff = (len > DEPTH) ? DEPTH : len;
        if (eff > 0) exp_q.push_back(ref_mem[addr]);
        if (cw) ref_mem[addr] = 8'(cw_data);
        for (int k = 1; k < eff; k++) exp_q.push_back(ref_mem[(addr + k) % DEPTH]);

        rd_start = 1'b1;
        rd_addr  = 3'(addr);
        rd_len   = 4'(len);
        wr_en    = cw;
        wr_addr  = 3'(addr);
        wr_data  = 8'(cw_data);
        @(negedge clk);
        rd_start = 1'b0;
        wr_en    = 1'b0;

        if (eff == 0) begin
            check(rd_busy, 0, "len0_busy");
            check(rd_valid, 0, "len0_valid");
            return;
        end

        i = 0;
        cyc = 0;
        while (i < eff && cyc < 200) begin
            check(rd_valid, 1, "valid");
            check(rd_busy, 1, "busy");
            check(rd_data, exp_q[i], "data");
            check(rd_last, (i == eff - 1), "last");
            rd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inject) begin
                rd_start = 1'b1;
                rd_addr  = 3'($urandom_range(0, 7));
                rd_len   = 4'($urandom_range(1, 15));
            end
            if (rd_ready) i++;
            cyc++;
            @(negedge clk);
        end
        rd_start = 1'b0;
        check(i, eff, "burst_words");
        check(rd_busy, 0, "end_busy");
        check(rd_valid, 0, "end_valid");
        check(rd_last, 0, "end_last");
        check(rd_data, exp_q[eff-1], "end_data_hold");
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_start = 1'b0; rd_addr = '0; rd_len = '0; rd_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check(rd_valid, 0, "rst_valid");
        check(rd_data, 0, "rst_data");
        check(rd_last, 0, "rst_last");
        check(rd_busy, 0, "rst_busy");
        rst = 1'b0;
        @(negedge clk);

        burst(0, 8, 0, 0, 0, 0);

        for (int k = 0; k < DEPTH; k++) do_write(k, 8'h10 + k);
        burst(2, 3, 0, 0, 0, 0);
        burst(6, 4, 0, 0, 0, 0);

        // Backpressure with a rewrite of the held address during the stall.
        rd_ready = 1'b0; rd_start = 1'b1; rd_addr = 3'd0; rd_len = 4'd2;
        @(negedge clk);
        rd_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check(rd_valid, 1, "bp_valid");
            check(rd_data, 8'h10, "bp_hold");
            check(rd_last, 0, "bp_last");
            wr_en = (c == 0); wr_addr = 3'd0; wr_data = 8'hAA;
            @(negedge clk);
        end
        wr_en = 1'b0;
        ref_mem[0] = 8'hAA;
        check(rd_data, 8'h10, "bp_first");
        rd_ready = 1'b1;
        @(negedge clk);
        check(rd_data, 8'h11, "bp_second");
        check(rd_last, 1, "bp_second_last");
        @(negedge clk);
        check(rd_busy, 0, "bp_done");

        burst(5, 0, 0, 0, 0, 0);
        burst(4, 3, 0, 1, 0, 0);
        burst(3, 1, 0, 0, 1, 8'h55);
        burst(3, 1, 0, 0, 0, 0);

        // Reset while the second word is presented.
        rd_ready = 1'b1; rd_start = 1'b1; rd_addr = 3'd0; rd_len = 4'd8;
        @(negedge clk);
        rd_start = 1'b0;
        check(rd_data, ref_mem[0], "mid_w0");
        @(negedge clk);
        check(rd_data, ref_mem[1], "mid_w1");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = 8'h00;
        check(rd_valid, 0, "mid_rst_valid");
        check(rd_busy, 0, "mid_rst_busy");
        check(rd_data, 0, "mid_rst_data");
        burst(0, 8, 0, 0, 0, 0);

        for (int n = 0; n < 30; n++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) do_write($urandom_range(0, 7), $urandom_range(0, 255));
            burst($urandom_range(0, 7), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regbank_stream_reader.md
Name: regbank_stream_reader

Overview:
- Read-side companion to the enable-register storage: a DEPTH x WIDTH bank of enable flip-flop registers with a simple write port and a burst read engine.
- The read engine streams consecutive words out over a valid/ready handshake.
- It sits between the register storage and any downstream consumer, such as a display or UART block, that needs to drain a block of registers without random-access timing.

Parameters:
- WIDTH, 8, data bits per register word
- DEPTH, 8, number of register words; power of two, >= 2
- AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  write strobe; mem[wr_addr] <= wr_data on the edge
- wr_addr  input  AW  write address
- wr_data  input  WIDTH  write data
- rd_start  input  1  begin a burst; sampled only in IDLE
- rd_addr  input  AW  first address of the burst, latched with rd_start
- rd_len  input  AW+1  burst length in words, 1..DEPTH; 0 means no burst
- rd_ready  input  1  consumer accepts the word on rd_data this cycle
- rd_valid  output  1  rd_data/rd_last hold a valid word
- rd_data  output  WIDTH  current word (registered)
- rd_last  output  1  current word is the final word of the burst
- rd_busy  output  1  burst in progress (state != IDLE)

Behaviour:
- Reset is synchronous (rst high at an edge) and has priority over everything.
  - All mem words go to 0, the FSM goes to IDLE, and the address pointer and remaining count go to 0.
  - rd_valid=0, rd_data=0, rd_last=0, rd_busy=0.
  - Reset during a burst aborts it; no further words are emitted.
- Write port:
  - Always active, including during a burst.
  - A write is visible to reads starting the following cycle.
- FSM states are IDLE and STREAM.
- IDLE:
  - rd_start=1 with rd_len!=0 loads rd_data <= mem[rd_addr] (pre-write value if the same edge writes that address).
  - The same edge sets ptr <= rd_addr+1 mod DEPTH, rem <= rd_len-1, rd_valid <= 1, rd_last <= (rd_len==1), rd_busy <= 1, and moves to STREAM.
  - Latency: first word valid one cycle after rd_start.
  - rd_start with rd_len==0 is ignored and the FSM stays in IDLE.
  - rd_len > DEPTH is clamped to DEPTH.
- STREAM:
  - While rd_ready=0, rd_data, rd_last and rd_valid hold stable, even if mem at that address is rewritten.
  - Handshake (rd_valid & rd_ready) with rd_last=1 clears rd_valid, rd_last and rd_busy on that edge and returns to IDLE. rd_data holds its last value.
  - Handshake with rd_last=0 performs these updates on the same edge, so back-to-back words stream at one word per clock:
    - rd_data <= mem[ptr], read-before-write on a same-edge write
    - ptr <= ptr+1 mod DEPTH
    - rem <= rem-1
    - rd_last <= (rem==1)
- Wrap-around: the address pointer wraps from DEPTH-1 to 0 silently.
- rd_start while in STREAM is ignored; no queueing.
- Exactly rd_len handshakes occur per burst; rd_last is asserted on exactly the final one.
- rd_valid never drops while rd_busy=1.
- rd_busy falls on the edge after the final handshake.

Test Plan:
- Reset fill check: after rst, burst rd_addr=0, rd_len=8 with rd_ready=1 -> eight words of 0x00, rd_valid high for 8 consecutive cycles, rd_last only on the 8th, rd_busy low the next cycle.
- Write then burst: write mem[i]=0x10+i for i=0..7; rd_addr=2, rd_len=3, rd_ready=1 -> 0x12, 0x13, 0x14 on consecutive cycles, with rd_last on 0x14.
- Wrap-around: same data, rd_addr=6, rd_len=4 -> 0x16, 0x17, 0x10, 0x11.
- Backpressure: rd_addr=0, rd_len=2, with rd_ready held low 3 cycles after the first valid -> 0x10 held stable for 3 cycles, then 0x10 then 0x11 accepted. Meanwhile, a write of 0xAA to mem[0] during the stall leaves rd_data at 0x10.
- Collisions/ignored requests:
  - rd_start with rd_len=0 -> rd_busy stays 0.
  - rd_start during STREAM -> no effect on the current burst.
  - A write to mem[3]=0x55 on the edge that loads addr 3 -> old 0x13 is emitted; a subsequent burst reads 0x55.
- Reset mid-burst: assert rst on the 2nd word of an rd_len=8 burst -> the next cycle has rd_valid=0, rd_busy=0 and rd_data=0, and a following burst from addr 0 returns 0x00.
